// File: rtl/debug_console_pkg.sv
// Shared constants for the debug console: debug I/O map, status word layout
// and transmitter state encoding.
package debug_console_pkg;

    localparam int unsigned DBG_ADDR_W = 10;

    localparam logic [DBG_ADDR_W-1:0] DBG_STAT_ADDR = 10'h3f0;
    localparam logic [DBG_ADDR_W-1:0] DBG_CHAR_ADDR = 10'h3f1;

    localparam int unsigned ST_EMPTY_BIT = 0;
    localparam int unsigned ST_FULL_BIT  = 1;
    localparam int unsigned ST_OVF_BIT   = 2;
    localparam int unsigned ST_TXACT_BIT = 3;
    localparam int unsigned ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [15:0] pack_status(
        input logic       empty,
        input logic       full,
        input logic       ovf,
        input logic       tx_active,
        input logic [7:0] count
    );
        logic [15:0] s;
        s = '0;
        s[ST_EMPTY_BIT]      = empty;
        s[ST_FULL_BIT]       = full;
        s[ST_OVF_BIT]        = ovf;
        s[ST_TXACT_BIT]      = tx_active;
        s[ST_COUNT_LSB +: 8] = count;
        return s;
    endfunction

endpackage

// File: rtl/debug_uart_tx.sv
// 8N1 serial transmitter; accepts a byte whenever ready is high and valid is
// asserted, chaining frames back to back without an idle gap.
module debug_uart_tx
    import debug_console_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       txd,
    output logic       active
);

    localparam int unsigned BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    tx_state_e     state_q;
    logic [BW-1:0] baud_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_q;
    logic          txd_q;
    logic          bit_end;

    assign bit_end = (baud_q == '0);
    // Accept a new byte from idle, or on the final stop-bit cycle to chain frames.
    assign ready   = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end);
    assign txd     = txd_q;
    assign active  = (state_q != TX_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (valid) begin
                        shift_q <= data;
                        bit_q   <= '0;
                        baud_q  <= BAUD_LAST;
                        txd_q   <= 1'b0;
                        state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        baud_q  <= BAUD_LAST;
                        txd_q   <= shift_q[0];
                        state_q <= TX_DATA;
                    end else begin
                        baud_q <= baud_q - BW'(1);
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        baud_q <= BAUD_LAST;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= TX_STOP;
                        end else begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            txd_q   <= shift_q[1];
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q - BW'(1);
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        if (valid) begin
                            shift_q <= data;
                            bit_q   <= '0;
                            baud_q  <= BAUD_LAST;
                            txd_q   <= 1'b0;
                            state_q <= TX_START;
                        end else begin
                            state_q <= TX_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - BW'(1);
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/debug_console.sv
// CPU debug console: captures character-port writes into a FIFO, serialises
// them as 8N1 on txd, and answers status reads on the shared data bus.
module debug_console
    import debug_console_pkg::*;
#(
    parameter int unsigned          DEPTH     = 16,
    parameter int unsigned          BAUD_DIV  = 434,
    parameter logic [DBG_ADDR_W-1:0] CHAR_ADDR = DBG_CHAR_ADDR,
    parameter logic [DBG_ADDR_W-1:0] STAT_ADDR = DBG_STAT_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] abus,
    inout  logic [15:0] dbus,
    input  logic        io,
    input  logic        r,
    input  logic        w,
    output logic        txd,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DBG_ADDR_W-1:0] addr;
    logic [15-DBG_ADDR_W:0] unused_abus;

    assign addr        = abus[DBG_ADDR_W-1:0];
    assign unused_abus = abus[15:DBG_ADDR_W];

    // Per strobe: bits [1:0] are the synchroniser, bit [2] the previous synced value.
    logic [2:0] io_sync_q;
    logic [2:0] r_sync_q;
    logic [2:0] w_sync_q;
    logic       io_s, r_s, w_s, io_p, r_p, w_p;

    logic [DBG_ADDR_W-1:0] wr_addr_q;
    logic [7:0]            wr_data_q;
    logic [DBG_ADDR_W-1:0] rd_addr_q;

    assign io_s = io_sync_q[1];
    assign r_s  = r_sync_q[1];
    assign w_s  = w_sync_q[1];
    assign io_p = io_sync_q[2];
    assign r_p  = r_sync_q[2];
    assign w_p  = w_sync_q[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            io_sync_q <= '1;
            r_sync_q  <= '1;
            w_sync_q  <= '1;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
        end else begin
            io_sync_q <= {io_sync_q[1:0], io};
            r_sync_q  <= {r_sync_q[1:0], r};
            w_sync_q  <= {w_sync_q[1:0], w};
            if (!io_s && !w_s) begin
                wr_addr_q <= addr;
                wr_data_q <= dbus[7:0];
            end
            if (!io_s && !r_s) begin
                rd_addr_q <= addr;
            end
        end
    end

    logic char_push;
    logic stat_done;

    assign char_push = w_s && !w_p && !io_p && (wr_addr_q == CHAR_ADDR);
    assign stat_done = r_s && !r_p && !io_p && (rd_addr_q == STAT_ADDR);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [PW-1:0] count;
    logic          empty, full, pop, push, ovf_set, ovf_q;
    logic          tx_ready, tx_active, tx_valid;
    logic [7:0]    tx_data;

    assign count    = wptr_q - rptr_q;
    assign empty    = (count == '0);
    assign full     = (count == PW'(DEPTH));
    assign tx_valid = !empty;
    assign tx_data  = mem_q[rptr_q[AW-1:0]];
    assign pop      = tx_ready && tx_valid;
    // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
    assign push     = char_push && (!full || pop);
    assign ovf_set  = char_push && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (stat_done) begin
                ovf_q <= 1'b0;
            end
        end
    end

    debug_uart_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_tx (
        .clk   (clk),
        .reset (reset),
        .valid (tx_valid),
        .data  (tx_data),
        .ready (tx_ready),
        .txd   (txd),
        .active(tx_active)
    );

    logic [15:0] status;
    logic        stat_rd;

    assign status  = pack_status(empty, full, ovf_q, tx_active, 8'(count));
    assign stat_rd = !io && !r && (addr == STAT_ADDR);
    assign dbus    = stat_rd ? status : 'z;
    assign busy    = tx_active || !empty;

endmodule

// File: tb/tb_debug_console.sv
// Randomised bus traffic against a frame-timing reference model of the debug
// console; txd and busy are compared every cycle, status on every read.
module tb_debug_console;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned BAUD   = 4;
    localparam logic [9:0]  CHAR_A = 10'h3f1;
    localparam logic [9:0]  STAT_A = 10'h3f0;
    localparam logic [15:0] BUS_Z  = 16'hFFFF;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [15:0] abus     = '0;
    logic        io       = 1'b1;
    logic        r        = 1'b1;
    logic        w        = 1'b1;
    logic [15:0] drv_data = '0;
    logic        drv_en   = 1'b0;
    logic        txd;
    logic        busy;
    wire  [15:0] dbus;

    assign dbus = drv_en ? drv_data : 16'hzzzz;

    for (genvar gi = 0; gi < 16; gi++) begin : g_pull
        pullup (dbus[gi]);
    end

    debug_console #(
        .DEPTH    (DEPTH),
        .BAUD_DIV (BAUD),
        .CHAR_ADDR(CHAR_A),
        .STAT_ADDR(STAT_A)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .abus (abus),
        .dbus (dbus),
        .io   (io),
        .r    (r),
        .w    (w),
        .txd  (txd),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a byte queue plus the time window of the frame on the wire.
    typedef struct {
        int unsigned edge_no;
        logic        is_push;
        logic [7:0]  data;
    } ev_t;

    int unsigned cyc         = 0;
    int unsigned frame_start = 0;
    int unsigned frame_end   = 0;
    logic [7:0]  cur_byte    = '0;
    logic        m_ovf       = 1'b0;
    logic [7:0]  q[$];
    ev_t         ev_q[$];
    logic        m_push, m_clr;
    logic [7:0]  m_pdata;
    logic        mon_en = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic exp_txd();
        int unsigned p;
        if (cyc >= frame_end) return 1'b1;
        p = (cyc - frame_start) / BAUD;
        if (p == 0) return 1'b0;
        if (p >= 9) return 1'b1;
        return cur_byte[p - 1];
    endfunction

    function automatic logic exp_busy();
        return (cyc < frame_end) || (q.size() > 0);
    endfunction

    function automatic logic [15:0] exp_status();
        logic [15:0] s;
        s       = '0;
        s[0]    = (q.size() == 0);
        s[1]    = (q.size() == int'(DEPTH));
        s[2]    = m_ovf;
        s[3]    = (cyc < frame_end);
        s[15:8] = 8'(q.size());
        return s;
    endfunction

    task automatic model_edge();
        cyc++;
        if (reset) begin
            q.delete();
            ev_q.delete();
            m_ovf       = 1'b0;
            frame_start = cyc;
            frame_end   = cyc;
        end else begin
            m_push = 1'b0;
            m_clr  = 1'b0;
            for (int i = ev_q.size() - 1; i >= 0; i--) begin
                if (ev_q[i].edge_no == cyc) begin
                    if (ev_q[i].is_push) begin
                        m_push  = 1'b1;
                        m_pdata = ev_q[i].data;
                    end else begin
                        m_clr = 1'b1;
                    end
                    ev_q.delete(i);
                end
            end
            if (cyc >= frame_end && q.size() > 0) begin
                cur_byte    = q.pop_front();
                frame_start = cyc;
                frame_end   = cyc + 10 * BAUD;
            end
            if (m_clr) m_ovf = 1'b0;
            if (m_push) begin
                if (q.size() < int'(DEPTH)) q.push_back(m_pdata);
                else m_ovf = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("txd", 16'(txd), 16'(exp_txd()));
            check("busy", 16'(busy), 16'(exp_busy()));
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Commit lands 3 edges after the raw /W rising edge.
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        ev_t ev;
        abus     = a;
        drv_data = d;
        drv_en   = 1'b1;
        io       = 1'b0;
        w        = 1'b0;
        step(3);
        w = 1'b1;
        if (a[9:0] == CHAR_A) begin
            ev.edge_no = cyc + 3;
            ev.is_push = 1'b1;
            ev.data    = d[7:0];
            ev_q.push_back(ev);
        end
        step(2);
        io     = 1'b1;
        drv_en = 1'b0;
        step(1);
    endtask

    task automatic bus_read(input logic [15:0] a, input string tag, output logic [15:0] got);
        ev_t ev;
        abus = a;
        io   = 1'b0;
        r    = 1'b0;
        step(3);
        @(negedge clk);
        got = dbus;
        if (a[9:0] == STAT_A) check(tag, got, exp_status());
        else check(tag, got, BUS_Z);
        @(posedge clk);
        #1;
        r = 1'b1;
        if (a[9:0] == STAT_A) begin
            ev.edge_no = cyc + 3;
            ev.is_push = 1'b0;
            ev.data    = '0;
            ev_q.push_back(ev);
        end
        step(2);
        io = 1'b1;
        step(1);
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    logic [15:0] got;
    logic [15:0] a16;
    logic [7:0]  pat;
    logic        found;
    int unsigned kind;

    initial begin
        step(3);
        reset  = 1'b0;
        mon_en = 1'b1;

        check("rst_txd", 16'(txd), 16'd1);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_dbus_z", dbus, BUS_Z);
        bus_read({6'd0, STAT_A}, "rst_stat", got);
        check("rst_stat_const", got, 16'h0001);

        // 'A' = 0x41 on the wire: start, LSB-first data, stop, 4 clocks each.
        bus_write(16'h03f1, 16'h0041);
        pat = 8'h41;
        step(1);
        for (int i = 0; i < 10; i++) begin
            step(1);
            @(negedge clk);
            if (i == 0) check("frame41_start", 16'(txd), 16'd0);
            else if (i == 9) check("frame41_stop", 16'(txd), 16'd1);
            else check("frame41_data", 16'(txd), 16'(pat[i - 1]));
            check("frame41_busy", 16'(busy), 16'd1);
            step(3);
        end
        check("frame41_done", 16'(busy), 16'd0);

        bus_write(16'h03f1, 16'h0048);
        bus_write(16'h03f1, 16'h0049);
        for (int i = 0; i < 300 && busy; i++) step(1);
        check("hi_done", 16'(busy), 16'd0);

        bus_write(16'h03f2, 16'h00AA);
        bus_write(16'h0007, 16'h0055);
        bus_read(16'h03f1, "rd_char_z", got);
        bus_read({6'd0, STAT_A}, "ign_stat", got);
        check("ign_stat_const", got, 16'h0001);

        for (int it = 0; it < 80; it++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 4) begin
                a16 = {6'($urandom), CHAR_A};
                bus_write(a16, 16'($urandom));
            end else if (kind == 5) begin
                a16 = 16'($urandom);
                if (a16[9:0] == CHAR_A) a16[0] = ~a16[0];
                bus_write(a16, 16'($urandom));
            end else if (kind == 6) begin
                a16 = {6'($urandom), STAT_A};
                bus_read(a16, "rnd_stat", got);
            end else if (kind == 7) begin
                a16 = 16'($urandom);
                bus_read(a16, "rnd_read", got);
            end else begin
                step($urandom_range(1, 50));
            end
        end

        for (int i = 0; i < 30; i++) begin
            bus_write({6'($urandom), CHAR_A}, 16'($urandom));
        end
        bus_read({6'd0, STAT_A}, "burst_stat", got);
        check("burst_ovf_set", 16'(got[2]), 16'd1);
        bus_read({6'd0, STAT_A}, "burst_stat2", got);
        check("burst_ovf_clr", 16'(got[2]), 16'd0);

        // Reset in the middle of data bit 3 with bytes still queued.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1);
            if (cyc < frame_end && (cyc - frame_start) / BAUD == 4) found = 1'b1;
        end
        check("rst2_window", 16'(found), 16'd1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rst2_txd", 16'(txd), 16'd1);
        bus_read({6'd0, STAT_A}, "rst2_stat", got);
        check("rst2_stat_const", got, 16'h0001);
        step(300);
        check("rst2_quiet_busy", 16'(busy), 16'd0);
        check("rst2_quiet_txd", 16'(txd), 16'd1);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
